// File: rtl/pipeline_elastic_pkg.sv
// pipeline_pkg: shared types and limits for the elastic pipeline.
package pipeline_pkg;

    // Largest supported number of register stages.
    localparam int unsigned PIPE_MAX_DEPTH = 16;

    // Sideband flags that travel in lockstep with each data beat.
    typedef struct packed {
        logic done;       // end of tile
        logic co_filter;  // filter-channel change
    } pipe_side_t;

endpackage

// File: rtl/pipeline_elastic_slot.sv
// pipe_slot: one elastic pipeline stage (valid bit, payload, sideband).
// Payload is captured only for valid beats; flush clears the valid bit only.
module pipe_slot
    import pipeline_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_load,
    input  logic                  i_flush,
    input  logic                  i_vld,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  pipe_side_t            i_side,
    output logic                  o_vld,
    output logic [DATA_WIDTH-1:0] o_data,
    output pipe_side_t            o_side
);

    logic                  r_vld;
    logic [DATA_WIDTH-1:0] r_data;
    pipe_side_t            r_side;

    // Valid bit: cleared by reset or flush, otherwise follows the upstream valid on load.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_vld <= 1'b0;
        end else if (i_flush) begin
            r_vld <= 1'b0;
        end else if (i_load) begin
            r_vld <= i_vld;
        end
    end

    // Payload and flags: captured only when a valid beat is loaded.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_data <= '0;
            r_side <= '0;
        end else if (i_load && i_vld && !i_flush) begin
            r_data <= i_data;
            r_side <= i_side;
        end
    end

    assign o_vld  = r_vld;
    assign o_data = r_data;
    assign o_side = r_side;

endmodule

// File: rtl/pipeline_elastic.sv
// pipeline_elastic: DEPTH-stage valid/ready pipeline with bubble collapsing
// and synchronous flush, carrying data plus done/co_filter sideband flags.
// Optional feature macro: PIPELINE_OCC_EN adds the registered occupancy output.
module pipeline_elastic
    import pipeline_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_done,
    input  logic                  in_co_filter,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_done,
    output logic                  out_co_filter
`ifdef PIPELINE_OCC_EN
    ,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
`endif
);

    logic [DEPTH:0]        w_rdy;
    logic [DEPTH-1:0]      w_load;
    logic [DEPTH-1:0]      w_vld;
    logic [DATA_WIDTH-1:0] w_data [DEPTH];
    pipe_side_t            w_side [DEPTH];
    pipe_side_t            w_in_side;

    assign w_in_side = '{done: in_done, co_filter: in_co_filter};

    // Ready chain, evaluated from the output stage back to the input stage.
    always_comb begin
        w_rdy        = '0;
        w_rdy[DEPTH] = out_ready;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            w_rdy[DEPTH-1-k] = !w_vld[DEPTH-1-k] || w_rdy[DEPTH-k];
        end
    end

    assign w_load   = w_rdy[DEPTH-1:0] & ~{DEPTH{flush}};
    assign in_ready = w_rdy[0] && !flush;

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        if (g == 0) begin : g_head
            pipe_slot #(.DATA_WIDTH(DATA_WIDTH)) u_slot (
                .clk    (clk),
                .rst    (rst),
                .i_load (w_load[g]),
                .i_flush(flush),
                .i_vld  (in_valid),
                .i_data (in_data),
                .i_side (w_in_side),
                .o_vld  (w_vld[g]),
                .o_data (w_data[g]),
                .o_side (w_side[g])
            );
        end else begin : g_body
            pipe_slot #(.DATA_WIDTH(DATA_WIDTH)) u_slot (
                .clk    (clk),
                .rst    (rst),
                .i_load (w_load[g]),
                .i_flush(flush),
                .i_vld  (w_vld[g-1]),
                .i_data (w_data[g-1]),
                .i_side (w_side[g-1]),
                .o_vld  (w_vld[g]),
                .o_data (w_data[g]),
                .o_side (w_side[g])
            );
        end
    end

    assign out_valid     = w_vld[DEPTH-1] && !flush;
    assign out_data      = w_data[DEPTH-1];
    assign out_done      = w_side[DEPTH-1].done;
    assign out_co_filter = w_side[DEPTH-1].co_filter;

`ifdef PIPELINE_OCC_EN
    localparam int unsigned OCC_W = $clog2(DEPTH+1);

    logic [OCC_W-1:0] r_occ;
    logic             w_in_xfer;
    logic             w_out_xfer;

    assign w_in_xfer  = in_valid && in_ready;
    assign w_out_xfer = out_valid && out_ready;

    // Occupancy tracks accepted minus emitted beats, which equals the set valid bits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_occ <= '0;
        end else if (flush) begin
            r_occ <= '0;
        end else begin
            r_occ <= r_occ + OCC_W'(w_in_xfer) - OCC_W'(w_out_xfer);
        end
    end

    assign occupancy = r_occ;
`endif

endmodule

// File: tb/tb_pipeline_elastic.sv
// tb_pipeline_elastic: randomized and directed checks of pipeline_elastic
// (DEPTH=3) against a beat-level reference model of sliding beats.
module tb_pipeline_elastic;

    localparam int D = 3;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         in_done;
    logic         in_co_filter;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         out_done;
    logic         out_co_filter;
`ifdef PIPELINE_OCC_EN
    logic [$clog2(D+1)-1:0] occupancy;
`endif

    pipeline_elastic #(.DATA_WIDTH(W), .DEPTH(D)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_done      (in_done),
        .in_co_filter (in_co_filter),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_done     (out_done),
        .out_co_filter(out_co_filter)
`ifdef PIPELINE_OCC_EN
        ,
        .occupancy    (occupancy)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: ordered list of beats in flight, each with its stage position.
    typedef struct {
        logic [W-1:0] data;
        logic         done;
        logic         cof;
        int           pos;
    } beat_t;

    beat_t mq[$];
    int    newp[D];
    bit    m_in_ready;
    bit    m_out_valid;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Each beat slides forward one position unless the beat ahead still occupies it.
    function automatic void plan();
        int prev;
        prev = out_ready ? D + 1 : D;
        for (int j = 0; j < mq.size(); j++) begin
            int p;
            p       = mq[j].pos;
            newp[j] = (p + 1 < prev) ? p + 1 : p;
            prev    = newp[j];
        end
        m_in_ready  = !flush && (mq.size() == 0 || newp[mq.size()-1] > 0);
        m_out_valid = !flush && mq.size() > 0 && mq[0].pos == D - 1;
    endfunction

    // Compare point, half a cycle away from the active edge.
    task automatic settle();
        @(negedge clk);
        plan();
        chk("in_ready", in_ready, m_in_ready);
        chk("out_valid", out_valid, m_out_valid);
        if (m_out_valid) begin
            chk("out_data", out_data, mq[0].data);
            chk("out_done", out_done, mq[0].done);
            chk("out_co_filter", out_co_filter, mq[0].cof);
        end
`ifdef PIPELINE_OCC_EN
        chk("occupancy", occupancy, mq.size());
`endif
    endtask

    task automatic advance();
        @(posedge clk);
        if (!rst || flush) begin
            mq.delete();
        end else begin
            plan();
            for (int j = 0; j < mq.size(); j++) mq[j].pos = newp[j];
            if (mq.size() > 0 && mq[0].pos == D) void'(mq.pop_front());
            if (in_valid && m_in_ready)
                mq.push_back('{data: in_data, done: in_done, cof: in_co_filter, pos: 0});
        end
        cyc++;
        #1;
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            settle();
            advance();
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_data"}, out_data, 0);
        chk({tag, "_out_done"}, out_done, 0);
        chk({tag, "_out_co_filter"}, out_co_filter, 0);
        chk({tag, "_in_ready"}, in_ready, 1);
`ifdef PIPELINE_OCC_EN
        chk({tag, "_occupancy"}, occupancy, 0);
`endif
    endtask

    int first_acc, first_out, last_out, exp_next, sent, flagged_seen;

    initial begin
        rst          = 1'b0;
        flush        = 1'b0;
        in_valid     = 1'b0;
        in_data      = '0;
        in_done      = 1'b0;
        in_co_filter = 1'b0;
        out_ready    = 1'b1;

        // Reset state.
        @(negedge clk);
        check_zero_outputs("reset");
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Streaming 0x01..0x10 with out_ready held high.
        first_acc = -1; first_out = -1; last_out = -1; exp_next = 1; sent = 0;
        for (int i = 0; i < 60 && exp_next <= 16; i++) begin
            in_valid = (sent < 16);
            in_data  = W'(sent + 1);
            settle();
            if (in_valid && in_ready && first_acc < 0) first_acc = cyc;
            if (out_valid) begin
                if (first_out < 0) first_out = cyc;
                last_out = cyc;
                chk("stream_order", out_data, exp_next);
                exp_next++;
            end
            if (in_valid && in_ready) sent++;
            advance();
        end
        chk("stream_latency", first_out - first_acc, 3);
        chk("stream_gapless", last_out - first_out, 15);
        chk("stream_count", exp_next - 1, 16);
        in_valid = 1'b0;
        step(2);

        // Fill with out_ready low: three accepts, then stall.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        sent      = 0;
        for (int i = 0; i < 5; i++) begin
            in_data = W'(sent + 1);
            settle();
            if (in_ready) sent++;
            advance();
        end
        in_data = 8'h99;
        settle();
        chk("fill_accepts", sent, 3);
        chk("fill_in_ready", in_ready, 0);
        chk("fill_out_valid", out_valid, 1);
        chk("fill_out_data", out_data, 8'h01);
`ifdef PIPELINE_OCC_EN
        chk("fill_occupancy", occupancy, 3);
`endif
        advance();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step(4);

        // Bubble collapse: only the last stage valid, downstream stalled.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h55;
        step(1);
        in_valid  = 1'b0;
        step(2);
        in_valid = 1'b1;
        in_data  = 8'hA0;
        settle();
        chk("bubble_a0_ready", in_ready, 1);
        advance();
        in_data = 8'hA1;
        settle();
        chk("bubble_a1_ready", in_ready, 1);
        advance();
        in_data = 8'hA2;
        settle();
        chk("bubble_full_ready", in_ready, 0);
        chk("bubble_head_data", out_data, 8'h55);
        advance();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step(5);

        // Sideband flags on exactly one beat.
        flagged_seen = 0;
        for (int i = 0; i < 9; i++) begin
            in_valid     = (i < 3);
            in_data      = W'(8'h30 + i);
            in_done      = (i == 1);
            in_co_filter = (i == 1);
            settle();
            if (out_valid) begin
                chk("flag_done", out_done, out_data == 8'h31);
                chk("flag_co_filter", out_co_filter, out_data == 8'h31);
                if (out_done) flagged_seen++;
            end
            advance();
        end
        chk("flag_seen_once", flagged_seen, 1);
        in_done      = 1'b0;
        in_co_filter = 1'b0;

        // Flush a full pipeline while a beat is offered.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = W'(8'h41 + i);
            step(1);
        end
        flush   = 1'b1;
        in_data = 8'hEE;
        settle();
        chk("flush_in_ready", in_ready, 0);
        chk("flush_out_valid", out_valid, 0);
        advance();
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        settle();
        chk("post_flush_out_valid", out_valid, 0);
        chk("post_flush_in_ready", in_ready, 1);
`ifdef PIPELINE_OCC_EN
        chk("post_flush_occupancy", occupancy, 0);
`endif
        advance();
        step(4);

        // Asynchronous reset in the middle of a stream.
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = W'(8'h60 + i);
            step(1);
        end
        #2;
        rst = 1'b0;
        #1;
        check_zero_outputs("async_reset");
        mq.delete();
        in_valid = 1'b0;
        step(1);
        rst = 1'b1;
        step(4);
        in_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_data = W'(8'h70 + i);
            step(1);
        end
        in_valid = 1'b0;
        step(5);

        // Randomized traffic with occasional flushes.
        for (int i = 0; i < 600; i++) begin
            in_valid     = ($urandom_range(0, 3) != 0);
            out_ready    = ($urandom_range(0, 3) != 0);
            flush        = ($urandom_range(0, 29) == 0);
            in_data      = W'($urandom);
            in_done      = 1'($urandom_range(0, 1));
            in_co_filter = 1'($urandom_range(0, 1));
            step(1);
        end
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step(5);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/pipeline_elastic.md
# pipeline_elastic

Parametrised, DEPTH-stage elastic pipeline that carries a data word plus the `done` and `co_filter` sideband flags between datapath blocks of the filter engine. Each stage holds a valid bit. Flow control is a valid/ready handshake with bubble collapsing, so an empty stage accepts new data while the stages after it are stalled. A synchronous flush discards everything in flight. It replaces chains of fixed single-stage stall registers between the fetch, filter and accumulate stages.

## Interface
Parameters:
- `DATA_WIDTH`, 8: width of the data word.
- `DEPTH`, 2: number of register stages; legal range is 1 to 16.

Ports:
- `clk` in, 1: the single clock; everything is rising-edge.
- `rst` in, 1: asynchronous reset, active-low (0 = reset).
- `flush` in, 1: synchronous discard of all stages.
- `in_valid` in, 1: upstream presents a beat.
- `in_ready` out, 1: the pipeline accepts a beat this cycle.
- `in_data` in, DATA_WIDTH: beat payload.
- `in_done` in, 1: sideband flag, end of tile.
- `in_co_filter` in, 1: sideband flag, filter-channel change.
- `out_valid` out, 1: the last stage holds a beat.
- `out_ready` in, 1: downstream accepts.
- `out_data` out, DATA_WIDTH: payload of the last stage.
- `out_done` out, 1: sideband flag of the last stage.
- `out_co_filter` out, 1: sideband flag of the last stage.
- `occupancy` out, $clog2(DEPTH+1): present only when `PIPELINE_OCC_EN` is defined.

## Operation
- Stages are numbered 0 (input) to DEPTH-1 (output). Each stage holds `vld[i]`, data, done and co_filter.
- Ready chain (combinational):
  - `rdy[DEPTH] = out_ready`
  - `rdy[i] = !vld[i] || rdy[i+1]`
  - `in_ready = rdy[0] && !flush`
- Stage i loads when `rdy[i]` is 1 and no flush is active.
  - Stage 0 takes `in_valid` and the in_* fields.
  - Stage i>0 takes `vld[i-1]` and the fields of stage i-1.
- When a stage does not load, its valid bit, data and flags all hold.
- Payload registers load only when the incoming valid is 1, so invalid data is never captured.
- Transfers:
  - Input transfer: `in_valid && in_ready`.
  - Output transfer: `out_valid && out_ready`.
  - Beats are never dropped, duplicated or reordered.
- Flush:
  - While `flush` is 1, `in_ready` = 0 and `out_valid` = 0; no transfer occurs.
  - On the next edge every `vld` clears. Payload registers hold and are don't-care.
- Sideband flags travel in lockstep with their data beat.
- `out_valid = vld[DEPTH-1] && !flush`. `out_data` and the flags come straight from the stage DEPTH-1 registers.

## Timing
- Reset (`rst` = 0, asynchronous): all `vld`, data and flags go to 0.
  - `out_valid` = 0, `out_data` = 0, `out_done` = 0, `out_co_filter` = 0, `occupancy` = 0.
  - `in_ready` = 1 during reset, because it is combinational from empty stages.
- Latency: a beat accepted at edge t appears on `out_valid` after edge t+DEPTH-1. That is DEPTH cycles of register delay when there is no backpressure.
- Throughput: one beat per cycle when `out_ready` is held at 1.
- Full pipeline (all `vld` = 1) with `out_ready` = 1: `in_ready` = 1, and a simultaneous in/out transfer keeps the pipeline full.
- Full pipeline with `out_ready` = 0: `in_ready` = 0, and every output holds stable.
- Bubble: with `out_ready` = 0 and only stage DEPTH-1 valid, stages 0..DEPTH-2 still fill, one per cycle.
- Flush has priority over all transfers in the same cycle.
- Reset asserted mid-stream clears everything immediately. No beat is emitted after reset is released until a new input transfer has completed.
- `in_ready` depends combinationally on `out_ready` through DEPTH levels. Upstream must not make `in_valid` depend on `in_ready`.

## Configuration
- `PIPELINE_OCC_EN`
  - Defined: adds the registered `occupancy` output, equal to the count of set `vld` bits after each edge. It is 0 after reset and after a flush, and its maximum is DEPTH.
  - Undefined: the port and its counter are absent, and behaviour is otherwise identical.

## Structure
- Package `pipeline_pkg`:
  - typedef `pipe_side_t`, a packed struct {done, co_filter};
  - constant `PIPE_MAX_DEPTH` = 16.
- Sub-module `pipe_slot`: one stage, holding a valid bit plus payload and `pipe_side_t`, with load/flush inputs. It is instantiated DEPTH times in a generate loop.

## Test plan
- Reset, then stream 0x01..0x10 with `out_ready`=1 and DEPTH=3. Expect the first `out_valid` 3 cycles after the first accept, then one beat per cycle in order, with no gaps.
- Fill DEPTH=3, hold `out_ready`=0. Expect `in_ready`=0 after 3 accepts, `out_data`=0x01 stable, and `occupancy`=3.
- With only the last stage valid and `out_ready`=0, offer 0xA0, 0xA1. Expect both accepted (bubble collapse), then `in_ready`=0.
- Send a beat with `in_done`=1 and `in_co_filter`=1 surrounded by beats with flags 0. Expect the flags to appear on exactly that beat's output cycle.
- Fill the pipeline, pulse `flush` with `in_valid`=1. Expect `in_ready`=0 and `out_valid`=0 that cycle, and all stages empty (`occupancy`=0) next cycle, with the offered beat not captured.
- Assert `rst`=0 asynchronously mid-stream. Expect all outputs 0 immediately, and output to resume only with new beats after release.
